mxint8_negate_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `mxint8_negate` datapath among `NUM_REQ` requesters. It accepts MXINT8 blocks (one shared scale plus `BLOCK_SIZE` elements) over per-requester valid/ready ports. It supports multi-block bursts that lock the grant, and returns negated blocks through a single registered output tagged with the requester id. It sits between the ALU front-end request ports and the shared negate unit.

---
 rtl/mxint8_pkg.sv | 23 ++
 rtl/mx_rr_arbiter.sv | 32 +++
 rtl/mxint8_negate.sv | 20 ++
 rtl/mxint8_negate_arb.sv | 137 +++++++++++++
 tb/tb_mxint8_negate_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mxint8_pkg.sv
// Shared MXINT8 constants, block type, arbiter FSM states and the
// saturating element negation used by the negate datapath.
package mxint8_pkg;

    localparam int BLOCK_SIZE           = 32;
    localparam int MXINT8_ELEMENT_WIDTH = 8;
    localparam int MXINT8_SCALE_WIDTH   = 8;

    // Element 0 sits at the most significant end of the packed block.
    typedef logic [0:BLOCK_SIZE-1][MXINT8_ELEMENT_WIDTH-1:0] mxint8_block_t;

    typedef enum logic {ARB, LOCKED} arb_state_e;

    // Two's-complement negation; -128 has no positive twin, so it clips to +127.
    function automatic logic [MXINT8_ELEMENT_WIDTH-1:0] neg_sat(
        input logic [MXINT8_ELEMENT_WIDTH-1:0] x
    );
        if (x == {1'b1, {(MXINT8_ELEMENT_WIDTH-1){1'b0}}})
            return {1'b0, {(MXINT8_ELEMENT_WIDTH-1){1'b1}}};
        return (~x) + 1'b1;
    endfunction

endpackage

// File: rtl/mx_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// searching cyclically. Grant is one-hot (all zero when nothing requests).
module mx_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic found;
    int   idx;

    // Walk the N positions starting at ptr, latching the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mxint8_negate.sv
// Combinational MXINT8 block negation: elements negated with saturation,
// shared scale passed through untouched.
module mxint8_negate
    import mxint8_pkg::*;
(
    input  logic [MXINT8_SCALE_WIDTH-1:0] in_scale,
    input  mxint8_block_t                 in_elements,
    output logic [MXINT8_SCALE_WIDTH-1:0] out_scale,
    output mxint8_block_t                 out_elements
);

    assign out_scale = in_scale;

    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
            assign out_elements[gi] = neg_sat(in_elements[gi]);
        end
    endgenerate

endmodule

// File: rtl/mxint8_negate_arb.sv
// Round-robin arbiter/sequencer sharing one mxint8_negate datapath among
// NUM_REQ requesters, with burst locking and a single registered output.
module mxint8_negate_arb #(
    parameter int NUM_REQ    = 4,
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_W     = 8,
    parameter int SCALE_W    = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ-1:0]                           req_last,
    input  logic [NUM_REQ-1:0][SCALE_W-1:0]              req_scale,
    input  logic [NUM_REQ-1:0][0:BLOCK_SIZE-1][ELEM_W-1:0] req_elements,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ID_W-1:0]                              out_id,
    output logic                                         out_last,
    output logic [SCALE_W-1:0]                           out_scale,
    output logic [0:BLOCK_SIZE-1][ELEM_W-1:0]            out_elements
);

    import mxint8_pkg::*;

    arb_state_e                      state_reg, state_next;
    logic [ID_W-1:0]                 rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]                 lock_id_reg, lock_id_next;

    logic [NUM_REQ-1:0]              arb_grant;
    logic [ID_W-1:0]                 arb_id;
    logic [ID_W-1:0]                 sel_id;
    logic                            can_load;
    logic                            xfer;
    logic                            xfer_last;

    logic [SCALE_W-1:0]              neg_scale;
    logic [0:BLOCK_SIZE-1][ELEM_W-1:0] neg_elements;

    logic                            out_valid_reg;
    logic [ID_W-1:0]                 out_id_reg;
    logic                            out_last_reg;
    logic [SCALE_W-1:0]              out_scale_reg;
    logic [0:BLOCK_SIZE-1][ELEM_W-1:0] out_elements_reg;

    mx_rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr_reg),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    assign can_load  = !out_valid_reg || out_ready;
    assign sel_id    = (state_reg == LOCKED) ? lock_id_reg : arb_id;
    assign xfer      = |(req_valid & req_ready);
    assign xfer_last = req_last[sel_id];

    // Ready goes only to the current grant (or the locked owner, valid or not).
    always_comb begin
        req_ready = '0;
        if (rst_n && can_load) begin
            if (state_reg == ARB)
                req_ready = arb_grant;
            else
                req_ready[lock_id_reg] = 1'b1;
        end
    end

    // Next-state: lock on a non-final block, unlock on the final one.
    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_id_next = lock_id_reg;
        if (xfer) begin
            if (state_reg == ARB) begin
                rr_ptr_next = (arb_id == ID_W'(NUM_REQ-1)) ? '0 : arb_id + ID_W'(1);
                if (!xfer_last) begin
                    state_next   = LOCKED;
                    lock_id_next = arb_id;
                end
            end else if (xfer_last) begin
                state_next  = ARB;
                rr_ptr_next = (lock_id_reg == ID_W'(NUM_REQ-1)) ? '0 : lock_id_reg + ID_W'(1);
            end
        end
    end

    mxint8_negate u_neg (
        .in_scale     (req_scale[sel_id]),
        .in_elements  (req_elements[sel_id]),
        .out_scale    (neg_scale),
        .out_elements (neg_elements)
    );

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ARB;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_id_reg <= lock_id_next;
        end
    end

    // Output register: load on request transfer, drain on output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg    <= 1'b0;
            out_id_reg       <= '0;
            out_last_reg     <= 1'b0;
            out_scale_reg    <= '0;
            out_elements_reg <= '0;
        end else if (xfer) begin
            out_valid_reg    <= 1'b1;
            out_id_reg       <= sel_id;
            out_last_reg     <= xfer_last;
            out_scale_reg    <= neg_scale;
            out_elements_reg <= neg_elements;
        end else if (out_ready) begin
            out_valid_reg    <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_id       = out_id_reg;
    assign out_last     = out_last_reg;
    assign out_scale    = out_scale_reg;
    assign out_elements = out_elements_reg;

endmodule

// File: tb/tb_mxint8_negate_arb.sv
// Directed bench for mxint8_negate_arb: reset, single block, fairness,
// burst lock, lock bubble, backpressure and mid-burst reset.
module tb_mxint8_negate_arb;

    logic                          clk;
    logic                          rst_n;
    logic [3:0]                    req_valid;
    logic [3:0]                    req_ready;
    logic [3:0]                    req_last;
    logic [3:0][7:0]               req_scale;
    logic [3:0][0:31][7:0]         req_elements;
    logic                          out_valid;
    logic                          out_ready;
    logic [1:0]                    out_id;
    logic                          out_last;
    logic [7:0]                    out_scale;
    logic [0:31][7:0]              out_elements;

    int total = 0;
    int bad   = 0;

    logic [0:31][7:0] exp_blk;
    logic [7:0]       neg_tab [4];

    mxint8_negate_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_last     (req_last),
        .req_scale    (req_scale),
        .req_elements (req_elements),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_last     (out_last),
        .out_scale    (out_scale),
        .out_elements (out_elements)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cycle();
        logic x;
        x = rst_n && |(req_valid & req_ready);
        @(posedge clk);
        #1;
        if (x)
            $display("txn: id=%0d last=%0b scale=%02h e0=%02h", out_id, out_last, out_scale, out_elements[0]);
    endtask

    task automatic fill(input int i, input logic [7:0] v);
        for (int j = 0; j < 32; j++) req_elements[i][j] = v;
    endtask

    task automatic chk_ready(input string tag, input logic [3:0] exp);
        #1;
        chk_val(tag, req_ready, exp);
    endtask

    task automatic grant_one(input string tag, input logic [3:0] rdy, input logic [1:0] id);
        chk_ready({tag, "_ready"}, rdy);
        cycle();
        chk_val({tag, "_valid"}, out_valid, 1'b1);
        chk_val({tag, "_id"}, out_id, id);
    endtask

    initial begin
        neg_tab[0] = 8'hFF; neg_tab[1] = 8'hFE; neg_tab[2] = 8'hFD; neg_tab[3] = 8'hFC;
        rst_n        = 1'b0;
        req_valid    = 4'hF;
        req_last     = 4'hF;
        req_scale    = '0;
        req_elements = '0;
        out_ready    = 1'b1;

        // Reset values
        #1;
        chk_val("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_out_id", out_id, 2'd0);
        chk_val("rst_out_scale", out_scale, 8'h00);
        chk_val("rst_out_elems", out_elements, 256'h0);
        chk_val("rst_req_ready", req_ready, 4'h0);
        req_valid = 4'h0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single block from requester 2 with saturation corner
        req_scale[2] = 8'h7F;
        req_elements[2][0] = 8'h01;
        req_elements[2][1] = 8'h80;
        req_elements[2][2] = 8'h00;
        req_elements[2][3] = 8'hFF;
        req_valid = 4'b0100;
        exp_blk = '0;
        exp_blk[0] = 8'hFF; exp_blk[1] = 8'h7F; exp_blk[2] = 8'h00; exp_blk[3] = 8'h01;
        chk_ready("single_ready", 4'b0100);
        req_valid = 4'b0100;
        cycle();
        req_valid = 4'h0;
        chk_val("single_valid", out_valid, 1'b1);
        chk_val("single_id", out_id, 2'd2);
        chk_val("single_last", out_last, 1'b1);
        chk_val("single_scale", out_scale, 8'h7F);
        chk_val("single_elems", out_elements, exp_blk);
        cycle();
        chk_val("single_drain", out_valid, 1'b0);

        // Fairness from a fresh pointer
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill(i, 8'(i + 1));
            req_scale[i] = 8'(8'h10 + i);
        end
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int k = 0; k < 8; k++) begin
            grant_one("fair", 4'(1 << (k % 4)), 2'(k % 4));
            chk_val("fair_elem", out_elements[31], neg_tab[k % 4]);
            chk_val("fair_scale", out_scale, 8'(8'h10 + k % 4));
        end
        req_valid = 4'h0;
        cycle();

        // Burst lock: move pointer to 1, then req 1 bursts 3 blocks
        req_valid = 4'b0001;
        grant_one("pre", 4'b0001, 2'd0);
        req_valid = 4'b1011;
        req_last  = 4'b1101;
        grant_one("burst1", 4'b0010, 2'd1);
        chk_val("burst1_last", out_last, 1'b0);
        grant_one("burst2", 4'b0010, 2'd1);
        req_last  = 4'b1111;
        grant_one("burst3", 4'b0010, 2'd1);
        chk_val("burst3_last", out_last, 1'b1);
        req_valid = 4'b1001;
        grant_one("after_burst_r3", 4'b1000, 2'd3);
        grant_one("after_burst_r0", 4'b0001, 2'd0);
        req_valid = 4'h0;
        cycle();

        // Lock bubble: pointer is 1, req 1 locks then drops valid
        req_valid = 4'b0011;
        req_last  = 4'b1101;
        grant_one("bub_lock", 4'b0010, 2'd1);
        req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            chk_ready("bub_ready", 4'b0010);
            cycle();
            chk_val("bub_no_grant", out_valid, 1'b0);
        end
        req_valid = 4'b0011;
        req_last  = 4'b1111;
        grant_one("bub_end", 4'b0010, 2'd1);
        req_valid = 4'b0001;
        grant_one("bub_r0", 4'b0001, 2'd0);
        req_valid = 4'h0;
        cycle();

        // Backpressure: pointer 1, req 2 fills output then stalls
        req_valid = 4'b0100;
        grant_one("bp_fill", 4'b0100, 2'd2);
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            chk_ready("bp_ready", 4'b0000);
            cycle();
            chk_val("bp_valid", out_valid, 1'b1);
            chk_val("bp_id", out_id, 2'd2);
            chk_val("bp_scale", out_scale, 8'h12);
            chk_val("bp_elem", out_elements[0], 8'hFD);
        end
        out_ready = 1'b1;
        grant_one("bp_r3", 4'b1000, 2'd3);
        grant_one("bp_r0", 4'b0001, 2'd0);
        req_valid = 4'h0;
        cycle();

        // Mid-burst reset: pointer 1, req 2 locks
        req_valid = 4'b0100;
        req_last  = 4'b1011;
        grant_one("mr_b1", 4'b0100, 2'd2);
        grant_one("mr_b2", 4'b0100, 2'd2);
        rst_n = 1'b0;
        #1;
        chk_val("mr_valid_clr", out_valid, 1'b0);
        chk_val("mr_ready_clr", req_ready, 4'h0);
        cycle();
        rst_n     = 1'b1;
        req_valid = 4'b0101;
        req_last  = 4'hF;
        grant_one("mr_first", 4'b0001, 2'd0);
        grant_one("mr_second", 4'b0100, 2'd2);
        req_valid = 4'h0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
